core_ifu_mem_resp: RTL

CORE_IFU_MEM_RESP -- requirements
Module: core_ifu_mem_resp

---
 rtl/core_ifu_mem_resp.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/core_ifu_mem_resp.sv
// Instruction-fetch memory responder.
// Serves fetch requests from an internal word array with a fixed request-to-response latency,
// in order, with a bounded number of outstanding requests and pipeline flush support.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_valid/req_ready   fetch request handshake, req_addr is the byte address
//   rsp_valid/rsp_ready   response handshake, rsp_data is the word, rsp_err flags an access fault
//   i_flush               discards everything outstanding (a same-cycle accept is kept)
//   wr_en/wr_addr/wr_data preload write port into the word array
module core_ifu_mem_resp #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2,
  parameter int unsigned QDEPTH  = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  input  logic          i_flush,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  // Registered stages ahead of the FIFO; the FIFO write itself is the final stage.
  localparam int unsigned NS = (LATENCY > 1) ? LATENCY - 1 : 1;

  // Aligned and inside the array.
  function automatic logic addr_ok(input logic [AW-1:0] a);
    return (a[1:0] == 2'b00) && ((a >> (IW + 2)) == '0);
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(QDEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Word array (not reset)
  // ---------------------------------------------------------------------------
  logic [DW-1:0] mem_q [DEPTH];
  logic          req_ok;
  logic          wr_ok;
  logic [DW-1:0] rd_word;
  logic          rd_err;

  assign req_ok  = addr_ok(req_addr);
  assign wr_ok   = addr_ok(wr_addr);
  // Combinational read sampled at the accept edge, so a same-cycle write returns old data.
  assign rd_word = req_ok ? mem_q[req_addr[IW+1:2]] : '0;
  assign rd_err  = ~req_ok;

  always_ff @(posedge clk) begin
    if (wr_en && wr_ok) begin
      mem_q[wr_addr[IW+1:2]] <= wr_data;
    end
  end

  // ---------------------------------------------------------------------------
  // Handshakes and outstanding count
  // ---------------------------------------------------------------------------
  logic       accept;
  logic       xfer;
  logic [2:0] count_q, count_d;

  assign req_ready = (count_q < 3'(QDEPTH));
  assign accept    = req_valid & req_ready;
  assign xfer      = rsp_valid & rsp_ready;

  always_comb begin
    count_d = count_q;
    if (i_flush) begin
      count_d = {2'b00, accept};
    end else begin
      unique case ({accept, xfer})
        2'b10:   count_d = count_q + 3'd1;
        2'b01:   count_d = count_q - 3'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Latency pipeline
  // ---------------------------------------------------------------------------
  logic          push_v;
  logic [DW-1:0] push_data;
  logic          push_err;

  if (LATENCY == 1) begin : g_direct
    assign push_v    = accept;
    assign push_data = rd_word;
    assign push_err  = rd_err;
  end else begin : g_pipe
    logic [NS-1:0] v_q;
    logic [NS-1:0] e_q;
    logic [DW-1:0] d_q [NS];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q <= '0;
        e_q <= '0;
        for (int i = 0; i < int'(NS); i++) begin
          d_q[i] <= '0;
        end
      end else begin
        // Stage 0 takes the accept unconditionally: a request accepted during flush survives.
        v_q[0] <= accept;
        d_q[0] <= rd_word;
        e_q[0] <= rd_err;
        for (int i = 1; i < int'(NS); i++) begin
          v_q[i] <= v_q[i-1] & ~i_flush;
          d_q[i] <= d_q[i-1];
          e_q[i] <= e_q[i-1];
        end
      end
    end

    assign push_v    = v_q[NS-1] & ~i_flush;
    assign push_data = d_q[NS-1];
    assign push_err  = e_q[NS-1];
  end

  // ---------------------------------------------------------------------------
  // Response FIFO; the outstanding limit keeps it from overflowing
  // ---------------------------------------------------------------------------
  logic [DW-1:0]     fifo_data_q [QDEPTH];
  logic [QDEPTH-1:0] fifo_err_q;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     wr_slot;
  logic [2:0]        fcnt_q, fcnt_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    fcnt_d   = fcnt_q;
    wr_slot  = wr_ptr_q;
    if (i_flush) begin
      // Everything is dropped; only a surviving LATENCY==1 accept lands in slot 0.
      rd_ptr_d = '0;
      wr_slot  = '0;
      wr_ptr_d = push_v ? ptr_inc('0) : '0;
      fcnt_d   = {2'b00, push_v};
    end else begin
      if (push_v) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (xfer)   rd_ptr_d = ptr_inc(rd_ptr_q);
      unique case ({push_v, xfer})
        2'b10:   fcnt_d = fcnt_q + 3'd1;
        2'b01:   fcnt_d = fcnt_q - 3'd1;
        default: fcnt_d = fcnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fcnt_q     <= '0;
      fifo_err_q <= '0;
      for (int i = 0; i < int'(QDEPTH); i++) begin
        fifo_data_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fcnt_q   <= fcnt_d;
      if (push_v) begin
        fifo_data_q[wr_slot] <= push_data;
        fifo_err_q[wr_slot]  <= push_err;
      end
    end
  end

  assign rsp_valid = (fcnt_q != 3'd0);
  assign rsp_data  = rsp_valid ? fifo_data_q[rd_ptr_q] : '0;
  assign rsp_err   = rsp_valid & fifo_err_q[rd_ptr_q];

endmodule
